// File: rtl/plic_claim_engine_if.sv
// Register-bus request/response bundle shared by the claim engine (master)
// and the bus mux in front of plic_top (slave).
interface plic_claim_engine_if;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        req_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        resp_ready;

  modport master (
    output req_addr, req_write, req_wdata, req_wstrb, req_valid,
    input  resp_rdata, resp_error, resp_ready
  );

  modport slave (
    input  req_addr, req_write, req_wdata, req_wstrb, req_valid,
    output resp_rdata, resp_error, resp_ready
  );
endinterface

// File: rtl/plic_claim_engine.sv
// Hardware claim/complete sequencer for one PLIC target: claims on eip, hands the
// ID to a consumer over valid/ready, then writes it back once the consumer is done.
module plic_claim_engine #(
  parameter logic [31:0] BASE_ADDR    = 32'h0C00_0000,
  parameter int unsigned TARGET       = 0,
  parameter int unsigned ID_W         = 5,
  parameter int unsigned DONE_TIMEOUT = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic                   irq_i,
  plic_claim_engine_if.master    reg_bus,
  output logic                   id_valid_o,
  output logic [ID_W-1:0]        id_o,
  input  logic                   id_ready_i,
  input  logic                   done_i,
  output logic                   busy_o,
  output logic [15:0]            claim_cnt_o,
  output logic [7:0]             spurious_cnt_o,
  output logic                   err_o,
  output logic                   timeout_o,
  input  logic                   clr_i
);

  localparam logic [31:0] CLAIM_ADDR =
      BASE_ADDR + 32'h0020_0004 + 32'(TARGET) * 32'h0000_1000;
  localparam int unsigned TMR_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST =
      TMR_W'((DONE_TIMEOUT == 0) ? 0 : DONE_TIMEOUT - 1);
  localparam bit TMR_EN = (DONE_TIMEOUT != 0);

  localparam logic [2:0] StIdle       = 3'd0;
  localparam logic [2:0] StClaimRd    = 3'd1;
  localparam logic [2:0] StDeliver    = 3'd2;
  localparam logic [2:0] StWaitDone   = 3'd3;
  localparam logic [2:0] StCompleteWr = 3'd4;

  logic [2:0]       r_state,       w_state_nxt;
  logic [31:0]      r_req_addr,    w_req_addr_nxt;
  logic             r_req_write,   w_req_write_nxt;
  logic [31:0]      r_req_wdata,   w_req_wdata_nxt;
  logic [3:0]       r_req_wstrb,   w_req_wstrb_nxt;
  logic             r_req_valid,   w_req_valid_nxt;
  logic [ID_W-1:0]  r_id,          w_id_nxt;
  logic [TMR_W-1:0] r_timer,       w_timer_nxt;
  logic [15:0]      r_claim_cnt;
  logic [7:0]       r_spur_cnt;
  logic             r_err;
  logic             r_tmo;

  logic             w_claim_inc;
  logic             w_spur_inc;
  logic             w_err_set;
  logic             w_tmo_set;
  logic             w_tmo_hit;
  logic [ID_W-1:0]  w_rd_id;
  logic             w_unused_rdata;

  // Only the low ID_W bits of the claim register carry the source ID.
  assign w_rd_id        = reg_bus.resp_rdata[ID_W-1:0];
  assign w_unused_rdata = ^reg_bus.resp_rdata[31:ID_W];
  assign w_tmo_hit      = TMR_EN && (r_timer == TMR_LAST);

  always_comb begin
    w_state_nxt     = r_state;
    w_req_addr_nxt  = r_req_addr;
    w_req_write_nxt = r_req_write;
    w_req_wdata_nxt = r_req_wdata;
    w_req_wstrb_nxt = r_req_wstrb;
    w_req_valid_nxt = r_req_valid;
    w_id_nxt        = r_id;
    w_timer_nxt     = r_timer;
    w_claim_inc     = 1'b0;
    w_spur_inc      = 1'b0;
    w_err_set       = 1'b0;
    w_tmo_set       = 1'b0;
    case (r_state)
      StIdle: begin
        if (enable_i && irq_i) begin
          w_state_nxt     = StClaimRd;
          w_req_addr_nxt  = CLAIM_ADDR;
          w_req_write_nxt = 1'b0;
          w_req_wdata_nxt = '0;
          w_req_wstrb_nxt = 4'h0;
          w_req_valid_nxt = 1'b1;
        end
      end
      StClaimRd: begin
        if (reg_bus.resp_ready) begin
          w_req_valid_nxt = 1'b0;
          w_req_addr_nxt  = '0;
          if (reg_bus.resp_error) begin
            w_err_set   = 1'b1;
            w_state_nxt = StIdle;
          end else if (w_rd_id == '0) begin
            w_spur_inc  = 1'b1;
            w_state_nxt = StIdle;
          end else begin
            w_id_nxt    = w_rd_id;
            w_claim_inc = 1'b1;
            w_state_nxt = StDeliver;
          end
        end
      end
      StDeliver: begin
        if (id_ready_i) begin
          w_state_nxt = StWaitDone;
          w_timer_nxt = '0;
        end
      end
      StWaitDone: begin
        // A done pulse on the timeout cycle wins: no flags are raised.
        if (done_i || w_tmo_hit) begin
          w_state_nxt     = StCompleteWr;
          w_req_addr_nxt  = CLAIM_ADDR;
          w_req_write_nxt = 1'b1;
          w_req_wdata_nxt = 32'(r_id);
          w_req_wstrb_nxt = 4'hF;
          w_req_valid_nxt = 1'b1;
          if (!done_i) begin
            w_tmo_set = 1'b1;
            w_err_set = 1'b1;
          end
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      StCompleteWr: begin
        if (reg_bus.resp_ready) begin
          w_err_set       = reg_bus.resp_error;
          w_state_nxt     = StIdle;
          w_req_addr_nxt  = '0;
          w_req_write_nxt = 1'b0;
          w_req_wdata_nxt = '0;
          w_req_wstrb_nxt = 4'h0;
          w_req_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StIdle;
      r_req_addr  <= '0;
      r_req_write <= 1'b0;
      r_req_wdata <= '0;
      r_req_wstrb <= 4'h0;
      r_req_valid <= 1'b0;
      r_id        <= '0;
      r_timer     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_addr  <= w_req_addr_nxt;
      r_req_write <= w_req_write_nxt;
      r_req_wdata <= w_req_wdata_nxt;
      r_req_wstrb <= w_req_wstrb_nxt;
      r_req_valid <= w_req_valid_nxt;
      r_id        <= w_id_nxt;
      r_timer     <= w_timer_nxt;
    end
  end

  // Counters saturate; clr_i beats any same-cycle increment or flag set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_claim_cnt <= '0;
      r_spur_cnt  <= '0;
      r_err       <= 1'b0;
      r_tmo       <= 1'b0;
    end else if (clr_i) begin
      r_claim_cnt <= '0;
      r_spur_cnt  <= '0;
      r_err       <= 1'b0;
      r_tmo       <= 1'b0;
    end else begin
      if (w_claim_inc && (r_claim_cnt != 16'hFFFF)) r_claim_cnt <= r_claim_cnt + 16'd1;
      if (w_spur_inc && (r_spur_cnt != 8'hFF))      r_spur_cnt  <= r_spur_cnt + 8'd1;
      if (w_err_set) r_err <= 1'b1;
      if (w_tmo_set) r_tmo <= 1'b1;
    end
  end

  assign reg_bus.req_addr  = r_req_addr;
  assign reg_bus.req_write = r_req_write;
  assign reg_bus.req_wdata = r_req_wdata;
  assign reg_bus.req_wstrb = r_req_wstrb;
  assign reg_bus.req_valid = r_req_valid;

  assign id_valid_o     = (r_state == StDeliver);
  assign id_o           = id_valid_o ? r_id : '0;
  assign busy_o         = (r_state != StIdle);
  assign claim_cnt_o    = r_claim_cnt;
  assign spurious_cnt_o = r_spur_cnt;
  assign err_o          = r_err;
  assign timeout_o      = r_tmo;

endmodule

// File: tb/tb_plic_claim_engine.sv
// Bench for plic_claim_engine: directed scenarios plus randomized claim/complete
// transactions scored against a transaction-level model.
module tb_plic_claim_engine;
  localparam int unsigned TMO    = 16;
  localparam logic [31:0] CLAIM0 = 32'h0C20_0004;
  localparam logic [31:0] CLAIM1 = 32'h0C20_1004;

  logic        clk = 1'b0;
  logic        rst_ni, enable, irq, id_ready, done, clr;
  logic        id_valid, busy, err, tmo;
  logic [4:0]  id_o;
  logic [15:0] claim_cnt;
  logic [7:0]  spur_cnt;

  logic        irq1, id_valid1, busy1, err1, tmo1;
  logic [4:0]  id_o1;
  logic [15:0] claim_cnt1;
  logic [7:0]  spur_cnt1;

  int n_cmp = 0;
  int n_err = 0;

  // Transaction-level model state
  int unsigned m_claim, m_spur;
  bit          m_err, m_tmo;

  plic_claim_engine_if bus0 ();
  plic_claim_engine_if bus1 ();

  plic_claim_engine #(
    .BASE_ADDR(32'h0C00_0000), .TARGET(0), .ID_W(5), .DONE_TIMEOUT(TMO)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable), .irq_i(irq), .reg_bus(bus0),
    .id_valid_o(id_valid), .id_o(id_o), .id_ready_i(id_ready), .done_i(done),
    .busy_o(busy), .claim_cnt_o(claim_cnt), .spurious_cnt_o(spur_cnt),
    .err_o(err), .timeout_o(tmo), .clr_i(clr)
  );

  plic_claim_engine #(
    .BASE_ADDR(32'h0C00_0000), .TARGET(1), .ID_W(5), .DONE_TIMEOUT(0)
  ) u_dut_t1 (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable), .irq_i(irq1), .reg_bus(bus1),
    .id_valid_o(id_valid1), .id_o(id_o1), .id_ready_i(1'b0), .done_i(1'b0),
    .busy_o(busy1), .claim_cnt_o(claim_cnt1), .spurious_cnt_o(spur_cnt1),
    .err_o(err1), .timeout_o(tmo1), .clr_i(1'b0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".claim_cnt"}, claim_cnt, m_claim);
    chk({tag, ".spur_cnt"}, spur_cnt, m_spur);
    chk({tag, ".err"}, err, m_err);
    chk({tag, ".timeout"}, tmo, m_tmo);
  endtask

  task automatic model_clear();
    m_claim = 0;
    m_spur  = 0;
    m_err   = 1'b0;
    m_tmo   = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".req_valid"}, bus0.req_valid, 1'b0);
    chk({tag, ".req_addr"}, bus0.req_addr, 32'h0);
    chk({tag, ".req_write"}, bus0.req_write, 1'b0);
    chk({tag, ".req_wdata"}, bus0.req_wdata, 32'h0);
    chk({tag, ".req_wstrb"}, bus0.req_wstrb, 4'h0);
    chk({tag, ".id_valid"}, id_valid, 1'b0);
    chk({tag, ".id_o"}, id_o, 5'h0);
    chk({tag, ".busy"}, busy, 1'b0);
    chk_model(tag);
  endtask

  // Slave side: hold the request lat cycles (checking it stays put), then respond.
  task automatic serve_bus(input string tag, input int lat, input logic wr,
                           input logic [31:0] wd, input logic rerr, input logic [31:0] rdata);
    for (int i = 0; i <= lat; i++) begin
      chk({tag, ".valid"}, bus0.req_valid, 1'b1);
      chk({tag, ".addr"}, bus0.req_addr, CLAIM0);
      chk({tag, ".write"}, bus0.req_write, wr);
      chk({tag, ".wstrb"}, bus0.req_wstrb, wr ? 4'hF : 4'h0);
      if (wr) chk({tag, ".wdata"}, bus0.req_wdata, wd);
      if (i == lat) begin
        bus0.resp_ready = 1'b1;
        bus0.resp_error = rerr;
        bus0.resp_rdata = rdata;
      end else begin
        bus0.resp_error = 1'($urandom_range(0, 1));
        bus0.resp_rdata = $urandom();
      end
      @(negedge clk);
    end
    bus0.resp_ready = 1'b0;
    bus0.resp_error = 1'($urandom_range(0, 1));
    bus0.resp_rdata = $urandom();
    chk({tag, ".drop"}, bus0.req_valid, 1'b0);
  endtask

  // One full claim sequence. done_k = WAIT_DONE cycle (1-based) carrying the done pulse.
  task automatic do_txn(input string tag, input int rd_lat, input logic rd_err,
                        input logic [31:0] rd_data, input int ack_lat, input int done_k,
                        input int wr_lat, input logic wr_err, input bit en_drop,
                        input bit rst_wr);
    logic [4:0] id;
    int         exp_wr;
    id  = rd_data[4:0];
    irq = 1'b1;
    @(negedge clk);
    chk({tag, ".busy_rd"}, busy, 1'b1);
    if (!en_drop) irq = 1'b0;
    serve_bus({tag, ".rd"}, rd_lat, 1'b0, 32'h0, rd_err, rd_data);
    if (rd_err || id == 5'd0) begin
      if (rd_err) m_err = 1'b1;
      else m_spur = (m_spur < 255) ? m_spur + 1 : m_spur;
      chk({tag, ".no_id"}, id_valid, 1'b0);
      chk({tag, ".idle"}, busy, 1'b0);
    end else begin
      m_claim = (m_claim < 65535) ? m_claim + 1 : m_claim;
      for (int i = 0; i <= ack_lat; i++) begin
        chk({tag, ".id_valid"}, id_valid, 1'b1);
        chk({tag, ".id"}, id_o, id);
        chk({tag, ".no_req"}, bus0.req_valid, 1'b0);
        if (en_drop) enable = 1'b0;
        done = 1'($urandom_range(0, 3) == 0);
        id_ready = (i == ack_lat);
        @(negedge clk);
      end
      id_ready = 1'b0;
      chk({tag, ".id_taken"}, id_valid, 1'b0);
      exp_wr = ((done_k <= int'(TMO)) ? done_k : int'(TMO)) + 1;
      for (int c = 1; c < exp_wr; c++) begin
        chk({tag, ".wait_no_req"}, bus0.req_valid, 1'b0);
        chk({tag, ".wait_busy"}, busy, 1'b1);
        done = (c == done_k);
        @(negedge clk);
      end
      done = 1'b0;
      if (done_k > int'(TMO)) begin
        m_tmo = 1'b1;
        m_err = 1'b1;
      end
      if (rst_wr) begin
        chk({tag, ".wr_up"}, bus0.req_valid, 1'b1);
        #2 rst_ni = 1'b0;
        model_clear();
        #1 chk_zero({tag, ".async"});
        @(negedge clk);
        rst_ni = 1'b1;
        return;
      end
      serve_bus({tag, ".wr"}, wr_lat, 1'b1, {27'h0, id}, wr_err, $urandom());
      if (wr_err) m_err = 1'b1;
      chk({tag, ".busy_end"}, busy, 1'b0);
    end
    if (en_drop) begin
      for (int i = 0; i < 4; i++) begin
        chk({tag, ".stay_idle"}, busy, 1'b0);
        chk({tag, ".stay_noreq"}, bus0.req_valid, 1'b0);
        @(negedge clk);
      end
      irq    = 1'b0;
      enable = 1'b1;
    end
    chk_model(tag);
  endtask

  initial begin
    logic [31:0] d;
    rst_ni = 1'b0; enable = 1'b1; irq = 1'b0; irq1 = 1'b0;
    id_ready = 1'b0; done = 1'b0; clr = 1'b0;
    bus0.resp_ready = 1'b0; bus0.resp_error = 1'b0; bus0.resp_rdata = '0;
    bus1.resp_ready = 1'b0; bus1.resp_error = 1'b0; bus1.resp_rdata = '0;
    model_clear();
    #3 chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    chk_zero("post_reset");

    do_txn("basic", 2, 1'b0, 32'h0000_0007, 0, 5, 0, 1'b0, 1'b0, 1'b0);

    // Spurious claim with irq still high: re-claim two cycles after the response.
    irq = 1'b1;
    @(negedge clk);
    serve_bus("spur.rd", 1, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFE0);
    m_spur++;
    chk("spur.no_id", id_valid, 1'b0);
    chk("spur.idle", busy, 1'b0);
    @(negedge clk);
    chk("spur.reclaim", bus0.req_valid, 1'b1);
    irq = 1'b0;
    serve_bus("spur.rd2", 0, 1'b0, 32'h0, 1'b0, 32'h0);
    m_spur++;
    chk_model("spur");

    do_txn("backpressure", 8, 1'b0, 32'hABCD_0013, 10, 3, 8, 1'b0, 1'b0, 1'b0);
    do_txn("coincide", 0, 1'b0, 32'h0000_0005, 0, TMO, 0, 1'b0, 1'b0, 1'b0);
    do_txn("timeout", 1, 1'b0, 32'h0000_001E, 0, 1000, 1, 1'b0, 1'b0, 1'b0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    chk_model("clr");

    do_txn("en_drop", 0, 1'b0, 32'h0000_0009, 1, 2, 0, 1'b0, 1'b1, 1'b0);

    // TARGET=1 instance: claim read returns an error.
    irq1 = 1'b1;
    @(negedge clk);
    chk("t1.valid", bus1.req_valid, 1'b1);
    chk("t1.addr", bus1.req_addr, CLAIM1);
    chk("t1.write", bus1.req_write, 1'b0);
    bus1.resp_ready = 1'b1; bus1.resp_error = 1'b1; bus1.resp_rdata = 32'h5;
    irq1 = 1'b0;
    @(negedge clk);
    bus1.resp_ready = 1'b0; bus1.resp_error = 1'b0;
    chk("t1.drop", bus1.req_valid, 1'b0);
    chk("t1.err", err1, 1'b1);
    chk("t1.no_id", id_valid1, 1'b0);
    chk("t1.idle", busy1, 1'b0);
    chk("t1.claim_cnt", claim_cnt1, 16'h0);

    for (int t = 0; t < 40; t++) begin
      d = $urandom();
      if ($urandom_range(0, 5) == 0) d = d & 32'hFFFF_FFE0;
      do_txn("rand", $urandom_range(0, 3), 1'($urandom_range(0, 7) == 0), d,
             $urandom_range(0, 3), $urandom_range(1, 20), $urandom_range(0, 3),
             1'($urandom_range(0, 7) == 0), 1'b0, 1'b0);
      if ($urandom_range(0, 7) == 0) begin
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
        chk_model("rand_clr");
      end
    end

    do_txn("rst_wr", 0, 1'b0, 32'h0000_0011, 0, 2, 0, 1'b0, 1'b0, 1'b1);
    do_txn("after_rst", 1, 1'b0, 32'h0000_0003, 0, 1, 1, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
